mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares one single-port memory bus between two requesters: the IF stage (M0, instruction fetch, read-only) and the MEM stage (M1, load/store).
- M1 takes its address, data and byte strobes from the EX-MEM stage.
- Grants one transaction at a time, holds the slave request stable until it is acknowledged, and returns a registered one-cycle ack plus read data.
- Drives hold flags so the pipeline stalls the stage whose access is still pending.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; the strobe width is DATA_W/8.
- TIMEOUT_CYCLES, 255, watchdog limit. Used only with MEM_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- m0_req_i  input  1  IF read request.
- m0_addr_i  input  ADDR_W  IF address.
- m0_rdata_o  output  DATA_W  IF read data.
- m0_ack_o  output  1  IF completion pulse.
- m1_req_i  input  1  MEM request.
- m1_we_i  input  1  MEM write enable.
- m1_addr_i  input  ADDR_W  MEM address.
- m1_wdata_i  input  DATA_W  MEM write data.
- m1_wstrb_i  input  DATA_W/8  MEM byte strobes.
- m1_rdata_o  output  DATA_W  MEM read data.
- m1_ack_o  output  1  MEM completion pulse.
- s_req_o  output  1  slave request.
- s_we_o  output  1  slave write enable.
- s_addr_o  output  ADDR_W  slave address.
- s_wdata_o  output  DATA_W  slave write data.
- s_wstrb_o  output  DATA_W/8  slave strobes.
- s_rdata_i  input  DATA_W  slave read data.
- s_ack_i  input  1  slave completion.
- hold_if_o  output  1  stall IF; combinational = m0_req_i & ~m0_ack_o.
- hold_mem_o  output  1  stall MEM; combinational = m1_req_i & ~m1_ack_o.
- bus_err_o  output  1  timeout pulse; constant 0 without the macro.

Behaviour:
- Reset (rst low, asynchronous, takes effect immediately):
  - state = IDLE, last_grant = M0.
  - s_req_o, s_we_o, s_addr_o, s_wdata_o, s_wstrb_o = 0.
  - m0_ack_o, m1_ack_o, bus_err_o = 0.
  - m0_rdata_o = 32'h00000013 (NOP). m1_rdata_o = 0.
  - Reset during BUSY abandons the transaction; s_req_o drops asynchronously.
- FSM states: IDLE, BUSY_M0, BUSY_M1.
- Eligibility in IDLE: a master is eligible when its req_i = 1 and its ack_o = 0. A master in its ack cycle is not eligible, which prevents a double issue.
- Arbitration in IDLE:
  - Only one eligible master: it is granted.
  - Both eligible: M1 wins, unless last_grant = M1, in which case M0 wins. When both are pending, grants alternate.
- On grant edge:
  - s_req_o <= 1 and the slave fields are latched.
  - M0 grant: s_we_o = 0, s_wstrb_o = 0, s_wdata_o = 0.
  - M1 grant: M1's we/wdata/wstrb are latched.
  - last_grant updates; state moves to BUSY_Mx.
- BUSY_Mx:
  - s_* outputs are held constant until s_ack_i is sampled 1.
  - On that edge: s_req_o <= 0, mx_ack_o <= 1 for exactly one cycle, state <= IDLE.
  - Read data: on a read, mx_rdata_o <= s_rdata_i. On an M1 write, m1_rdata_o is unchanged.
- Latency: request sampled at edge N; s_req_o is high after N; earliest s_ack_i is sampled at N+1; mx_ack_o is high during cycle N+1..N+2. Minimum 2 cycles. Back-to-back grants have one IDLE cycle between them.
- If a requester drops req before ack, the transaction still completes and the ack pulse is still issued.
- Requester inputs may change freely during BUSY; they are not used there.
- s_ack_i is ignored in IDLE.
- m0_rdata_o/m1_rdata_o hold their values between transactions.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on grant and increments every BUSY cycle without s_ack_i.
  - When it equals TIMEOUT_CYCLES with no ack: s_req_o <= 0, mx_ack_o and bus_err_o pulse 1 for one cycle, state <= IDLE.
  - mx_rdata_o is loaded with NOP for M0 and with 0 for M1.
  - An ack arriving in the same cycle as the limit wins: normal completion, no error.
- Undefined: no counter; bus_err_o = 0; BUSY waits indefinitely.

Test Plan:
- M0 read, addr 0x100, slave acks 1 cycle after s_req_o with 0xDEADBEEF -> m0_ack_o pulses once at cycle N+1; m0_rdata_o = 0xDEADBEEF; s_we_o = 0.
- M1 write, addr 0x2004, data 0x12345678, wstrb 4'b0011, ack delayed 3 cycles -> s_* stable for all 4 BUSY cycles; m1_ack_o single pulse; m1_rdata_o unchanged; hold_mem_o high until the ack cycle.
- M0 and M1 both request continuously, slave acks immediately -> grant order M1, M0, M1, M0; each ack is a single pulse; no double issue.
- Reset asserted mid BUSY_M1 -> s_req_o = 0 immediately, all outputs at reset values; first request after release is granted normally.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 4, slave never acks an M0 read -> after 4 BUSY cycles, m0_ack_o = 1 and bus_err_o = 1 for one cycle, m0_rdata_o = 0x00000013, FSM returns to IDLE.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter (M0 = IF reads, M1 = MEM loads/stores) for one single-port memory bus.
// Define MEM_ARB_TIMEOUT_EN to add a watchdog that aborts a stalled slave access and pulses bus_err_o.
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req_i,
  input  logic [ADDR_W-1:0]     m0_addr_i,
  output logic [DATA_W-1:0]     m0_rdata_o,
  output logic                  m0_ack_o,
  input  logic                  m1_req_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_W-1:0]     m1_addr_i,
  input  logic [DATA_W-1:0]     m1_wdata_i,
  input  logic [DATA_W/8-1:0]   m1_wstrb_i,
  output logic [DATA_W-1:0]     m1_rdata_o,
  output logic                  m1_ack_o,
  output logic                  s_req_o,
  output logic                  s_we_o,
  output logic [ADDR_W-1:0]     s_addr_o,
  output logic [DATA_W-1:0]     s_wdata_o,
  output logic [DATA_W/8-1:0]   s_wstrb_o,
  input  logic [DATA_W-1:0]     s_rdata_i,
  input  logic                  s_ack_i,
  output logic                  hold_if_o,
  output logic                  hold_mem_o,
  output logic                  bus_err_o
);

  localparam logic [DATA_W-1:0] NOP = DATA_W'(32'h0000_0013);

  typedef enum logic [1:0] {IDLE, BUSY_M0, BUSY_M1} state_t;

  state_t state, state_nxt;
  logic   last_m1;
  logic   elig0, elig1;
  logic   grant0, grant1;
  logic   done, tout;

  // A master sitting in its ack cycle must not be re-granted for the same request.
  assign elig0      = m0_req_i & ~m0_ack_o;
  assign elig1      = m1_req_i & ~m1_ack_o;
  assign hold_if_o  = m0_req_i & ~m0_ack_o;
  assign hold_mem_o = m1_req_i & ~m1_ack_o;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tcnt;
  logic [TW-1:0] tcnt_inc;

  assign tcnt_inc = tcnt + TW'(1);
  // An ack in the limit cycle takes priority over the timeout.
  assign tout     = (state != IDLE) & ~s_ack_i & (tcnt_inc == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt      <= '0;
      bus_err_o <= 1'b0;
    end else begin
      bus_err_o <= tout;
      if (grant0 | grant1 | tout) tcnt <= '0;
      else if (state != IDLE && !s_ack_i) tcnt <= tcnt_inc;
    end
  end
`else
  assign tout      = 1'b0;
  assign bus_err_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        // With both pending, M1 wins unless it had the previous grant.
        grant1 = elig1 & (~elig0 | ~last_m1);
        grant0 = elig0 & ~grant1;
        if (grant1)      state_nxt = BUSY_M1;
        else if (grant0) state_nxt = BUSY_M0;
      end
      BUSY_M0, BUSY_M1: begin
        if (s_ack_i) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (tout) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_m1    <= 1'b0;
      s_req_o    <= 1'b0;
      s_we_o     <= 1'b0;
      s_addr_o   <= '0;
      s_wdata_o  <= '0;
      s_wstrb_o  <= '0;
      m0_ack_o   <= 1'b0;
      m1_ack_o   <= 1'b0;
      m0_rdata_o <= NOP;
      m1_rdata_o <= '0;
    end else begin
      m0_ack_o <= 1'b0;
      m1_ack_o <= 1'b0;
      if (grant0 | grant1) begin
        s_req_o   <= 1'b1;
        s_addr_o  <= grant1 ? m1_addr_i : m0_addr_i;
        s_we_o    <= grant1 & m1_we_i;
        s_wdata_o <= grant1 ? m1_wdata_i : '0;
        s_wstrb_o <= grant1 ? m1_wstrb_i : '0;
        last_m1   <= grant1;
      end
      if (done) begin
        s_req_o <= 1'b0;
        if (state == BUSY_M0) begin
          m0_ack_o   <= 1'b1;
          m0_rdata_o <= s_rdata_i;
        end else begin
          m1_ack_o <= 1'b1;
          if (!s_we_o) m1_rdata_o <= s_rdata_i;
        end
      end else if (tout) begin
        s_req_o <= 1'b0;
        if (state == BUSY_M0) begin
          m0_ack_o   <= 1'b1;
          m0_rdata_o <= NOP;
        end else begin
          m1_ack_o   <= 1'b1;
          m1_rdata_o <= '0;
        end
      end
    end
  end

endmodule
